dmem_block_responder: RTL and testbench

- Main-memory side of the data-cache memory interface.
- Answers the cache's read requests with 4-word block bursts.
- Answers the cache's write-through single-word writes.
- Sits between the D-cache memory interface and the behavioural data store in LC3_Cache-level benches and top-level integrations.
- Owns the data array, programmable access latency and the rrdy/rdrdy/wacpt handshake.

---
 rtl/dmem_block_responder_if.sv | 26 ++
 rtl/dmem_block_responder.sv | 173 +++++++++++++++++
 tb/tb_dmem_block_responder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_block_responder_if.sv
// Cache-to-memory data bus: block read requests/bursts and single-word write-through.
// The cache drives the master side, the memory responder the slave side.
interface dmem_block_responder_if #(
  parameter int ADDR_WD = 16,
  parameter int DATA_WD = 16
);
  logic               rrqst;
  logic               wrqst;
  logic               rdacpt;
  logic [ADDR_WD-1:0] maddr;
  logic [DATA_WD-1:0] mdin;
  logic               rrdy;
  logic               rdrdy;
  logic [DATA_WD-1:0] mdout;
  logic               wacpt;

  modport master (
    output rrqst, wrqst, rdacpt, maddr, mdin,
    input  rrdy, rdrdy, mdout, wacpt
  );

  modport slave (
    input  rrqst, wrqst, rdacpt, maddr, mdin,
    output rrdy, rdrdy, mdout, wacpt
  );
endinterface

// File: rtl/dmem_block_responder.sv
// Main-memory responder for the D-cache: 4-word block read bursts with a programmable
// latency, latency-delayed single-word writes, and a backdoor preload port.
module dmem_block_responder #(
  parameter int ADDR_WD = 16,
  parameter int DATA_WD = 16,
  parameter int MEM_AW  = 12,
  parameter int RD_LAT  = 4,
  parameter int WR_LAT  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  dmem_block_responder_if.slave bus,
  output logic [2:0]           mstate,
  output logic [1:0]           wcnt,
  input  logic                 ld_en,
  input  logic [MEM_AW-1:0]    ld_addr,
  input  logic [DATA_WD-1:0]   ld_data
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RACC   = 3'd1,
    RWAIT  = 3'd2,
    RBURST = 3'd3,
    WWAIT  = 3'd4,
    WDONE  = 3'd5
  } state_e;

  localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_LAT - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [MEM_AW-3:0]   base_q, base_d;
  logic [MEM_AW-1:0]   waddr_q, waddr_d;
  logic [DATA_WD-1:0]  wdata_q, wdata_d;
  logic [1:0]          wcnt_q, wcnt_d;
  logic [DATA_WD-1:0]  mdout_q, mdout_d;
  logic                rrdy_q, rrdy_d;
  logic                rdrdy_q, rdrdy_d;
  logic                wacpt_q, wacpt_d;

  logic [DATA_WD-1:0]  mem [2**MEM_AW];
  logic                mem_we;
  logic [MEM_AW-1:0]   mem_waddr;
  logic [DATA_WD-1:0]  mem_wdata;
  logic [1:0]          wcnt_nxt;

  // Upper address bits beyond the array are deliberately ignored.
  logic unused_maddr_hi;
  assign unused_maddr_hi = ^bus.maddr[ADDR_WD-1:MEM_AW];

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wcnt_d    = wcnt_q;
    mdout_d   = mdout_q;
    rrdy_d    = 1'b0;
    rdrdy_d   = rdrdy_q;
    wacpt_d   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ld_addr;
    mem_wdata = ld_data;
    wcnt_nxt  = wcnt_q + 2'd1;

    unique case (state_q)
      IDLE: begin
        mem_we = ld_en;
        // Write wins; a simultaneous read stays asserted and is picked up on return to IDLE.
        if (bus.wrqst) begin
          waddr_d = bus.maddr[MEM_AW-1:0];
          wdata_d = bus.mdin;
          cnt_d   = WR_LOAD;
          state_d = WWAIT;
        end else if (bus.rrqst) begin
          base_d  = bus.maddr[MEM_AW-1:2];
          rrdy_d  = 1'b1;
          state_d = RACC;
        end
      end
      RACC: begin
        cnt_d = RD_LOAD;
        if (RD_LOAD == 4'd0) begin
          mdout_d = mem[{base_q, 2'b00}];
          rdrdy_d = 1'b1;
          wcnt_d  = 2'd0;
          state_d = RBURST;
        end else begin
          state_d = RWAIT;
        end
      end
      RWAIT: begin
        // Leaving as the count reaches zero puts rdrdy exactly RD_LAT cycles after rrdy.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          mdout_d = mem[{base_q, 2'b00}];
          rdrdy_d = 1'b1;
          wcnt_d  = 2'd0;
          state_d = RBURST;
        end
      end
      RBURST: begin
        if (bus.rdacpt) begin
          if (wcnt_q == 2'd3) begin
            rdrdy_d = 1'b0;
            wcnt_d  = 2'd0;
            state_d = IDLE;
          end else begin
            wcnt_d  = wcnt_nxt;
            mdout_d = mem[{base_q, wcnt_nxt}];
          end
        end
      end
      WWAIT: begin
        if (cnt_q == 4'd0) begin
          mem_we    = 1'b1;
          mem_waddr = waddr_q;
          mem_wdata = wdata_q;
          wacpt_d   = 1'b1;
          state_d   = WDONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wcnt_q  <= '0;
      mdout_q <= '0;
      rrdy_q  <= 1'b0;
      rdrdy_q <= 1'b0;
      wacpt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wcnt_q  <= wcnt_d;
      mdout_q <= mdout_d;
      rrdy_q  <= rrdy_d;
      rdrdy_q <= rdrdy_d;
      wacpt_q <= wacpt_d;
    end
  end

  // NOTE: the data array has no reset; its contents must survive a reset of the control logic.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.rrdy  = rrdy_q;
  assign bus.rdrdy = rdrdy_q;
  assign bus.mdout = mdout_q;
  assign bus.wacpt = wacpt_q;
  assign mstate    = state_q;
  assign wcnt      = wcnt_q;

endmodule

// File: tb/tb_dmem_block_responder.sv
// Scoreboarded bench for dmem_block_responder: expected burst words are queued from a
// reference array when a read is issued and compared as each word is accepted.
module tb_dmem_block_responder;
  localparam int ADDR_WD = 16;
  localparam int DATA_WD = 16;
  localparam int MEM_AW  = 12;
  localparam int RD_LAT  = 4;
  localparam int WR_LAT  = 2;

  logic                clock;
  logic                reset;
  logic [2:0]          mstate;
  logic [1:0]          wcnt;
  logic                ld_en;
  logic [MEM_AW-1:0]   ld_addr;
  logic [DATA_WD-1:0]  ld_data;

  dmem_block_responder_if #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD)) bus ();

  dmem_block_responder #(
    .ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .MEM_AW(MEM_AW),
    .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .mstate  (mstate),
    .wcnt    (wcnt),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [DATA_WD-1:0] model_mem [2**MEM_AW];
  logic [DATA_WD-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [MEM_AW-1:0] addr, input logic [DATA_WD-1:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    model_mem[addr] = data;
    step();
    ld_en = 1'b0;
  endtask

  // Issues a read and pushes the four expected words; returns after the rrdy cycle.
  task automatic issue_read(input logic [ADDR_WD-1:0] addr);
    logic [MEM_AW-1:0] base;
    base = {addr[MEM_AW-1:2], 2'b00};
    for (int k = 0; k < 4; k++) exp_q.push_back(model_mem[base + MEM_AW'(k)]);
    bus.rrqst = 1'b1;
    bus.maddr = addr;
    step();
    bus.rrqst = 1'b0;
    chk("rrdy_on_accept", 32'(bus.rrdy), 32'd1);
    chk("mstate_racc", 32'(mstate), 32'd1);
  endtask

  // Runs from the rrdy cycle through the end of the burst, optionally stalling one word.
  task automatic run_burst(input int stall_word, input int stall_cycles);
    int lat = 1;
    int idx = 0;
    int stalls = 0;
    int guard = 0;
    logic [DATA_WD-1:0] exp_word;
    step();
    chk("rrdy_single_pulse", 32'(bus.rrdy), 32'd0);
    while (bus.rdrdy !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk("read_latency", 32'(lat), 32'(RD_LAT));
    while (idx < 4 && guard < 40) begin
      exp_word = exp_q[0];
      if (bus.rdrdy !== 1'b1 || bus.mdout !== exp_word || wcnt !== 2'(idx)) begin
        n_checks++;
        n_fail++;
        $display("FAIL burst_word%0d: rdrdy=%0b mdout=0x%0h wcnt=%0d expected rdrdy=1 mdout=0x%0h wcnt=%0d",
                 idx, bus.rdrdy, bus.mdout, wcnt, exp_word, idx);
      end else begin
        n_checks++;
      end
      if (idx == stall_word && stalls < stall_cycles) begin
        bus.rdacpt = 1'b0;
        stalls++;
      end else begin
        bus.rdacpt = 1'b1;
        void'(exp_q.pop_front());
        idx++;
      end
      step();
      guard++;
    end
    bus.rdacpt = 1'b0;
    chk("rdrdy_drop_after_burst", 32'(bus.rdrdy), 32'd0);
    chk("mstate_idle_after_burst", 32'(mstate), 32'd0);
  endtask

  task automatic do_write(input logic [ADDR_WD-1:0] addr, input logic [DATA_WD-1:0] data);
    int cyc = 1;
    bus.wrqst = 1'b1;
    bus.maddr = addr;
    bus.mdin  = data;
    step();
    bus.wrqst = 1'b0;
    while (bus.wacpt !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("write_latency", 32'(cyc), 32'(WR_LAT + 1));
    chk("mstate_wdone", 32'(mstate), 32'd5);
    model_mem[addr[MEM_AW-1:0]] = data;
    step();
    chk("wacpt_single_pulse", 32'(bus.wacpt), 32'd0);
    chk("mstate_idle_after_write", 32'(mstate), 32'd0);
  endtask

  task automatic test_reset();
    chk("reset_rrdy", 32'(bus.rrdy), 32'd0);
    chk("reset_rdrdy", 32'(bus.rdrdy), 32'd0);
    chk("reset_wacpt", 32'(bus.wacpt), 32'd0);
    chk("reset_mstate", 32'(mstate), 32'd0);
    chk("reset_mdout", 32'(bus.mdout), 32'd0);
    chk("reset_wcnt", 32'(wcnt), 32'd0);
    bus.rdacpt = 1'b1;
    step();
    bus.rdacpt = 1'b0;
    step();
    chk("idle_rdacpt_mstate", 32'(mstate), 32'd0);
    chk("idle_rdacpt_rdrdy", 32'(bus.rdrdy), 32'd0);
    chk("idle_rdacpt_wcnt", 32'(wcnt), 32'd0);
  endtask

  task automatic test_read();
    for (int k = 0; k < 4; k++) preload(MEM_AW'(12'h104 + k), DATA_WD'(16'hA000 + k));
    issue_read(16'h0106);
    run_burst(-1, 0);
  endtask

  task automatic test_stall();
    issue_read(16'h0106);
    run_burst(2, 3);
  endtask

  task automatic test_write_readback();
    do_write(16'h0105, 16'h5A5A);
    chk("model_word1", 32'(model_mem[12'h105]), 32'h5A5A);
    issue_read(16'h0104);
    run_burst(-1, 0);
  endtask

  task automatic test_simultaneous();
    int cyc = 1;
    bus.rrqst = 1'b1;
    bus.wrqst = 1'b1;
    bus.maddr = 16'h0106;
    bus.mdin  = 16'h1234;
    step();
    bus.wrqst = 1'b0;
    chk("simul_write_first", 32'(mstate), 32'd4);
    chk("simul_no_rrdy", 32'(bus.rrdy), 32'd0);
    while (bus.wacpt !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("simul_write_latency", 32'(cyc), 32'(WR_LAT + 1));
    model_mem[12'h106] = 16'h1234;
    for (int k = 0; k < 4; k++) exp_q.push_back(model_mem[12'h104 + k]);
    step();
    chk("simul_idle_between", 32'(mstate), 32'd0);
    step();
    bus.rrqst = 1'b0;
    chk("simul_rrdy_follows", 32'(bus.rrdy), 32'd1);
    run_burst(-1, 0);
  endtask

  task automatic test_reset_wrap();
    int lat = 1;
    issue_read(16'h0104);
    step();
    while (bus.rdrdy !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    bus.rdacpt = 1'b1;
    step();
    bus.rdacpt = 1'b0;
    chk("midburst_wcnt", 32'(wcnt), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_rdrdy", 32'(bus.rdrdy), 32'd0);
    chk("abort_mstate", 32'(mstate), 32'd0);
    chk("abort_mdout", 32'(bus.mdout), 32'd0);
    chk("abort_wcnt", 32'(wcnt), 32'd0);
    exp_q.delete();
    step();
    reset = 1'b0;
    // A write aborted before its commit must leave the array untouched.
    bus.wrqst = 1'b1;
    bus.maddr = 16'h0104;
    bus.mdin  = 16'hDEAD;
    step();
    bus.wrqst = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("abort_write_wacpt", 32'(bus.wacpt), 32'd0);
    step();
    reset = 1'b0;
    do_write(16'h1105, 16'hBEEF);
    chk("wrap_model", 32'(model_mem[12'h105]), 32'hBEEF);
    issue_read(16'h0104);
    run_burst(-1, 0);
  endtask

  initial begin
    reset      = 1'b1;
    ld_en      = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    bus.rrqst  = 1'b0;
    bus.wrqst  = 1'b0;
    bus.rdacpt = 1'b0;
    bus.maddr  = '0;
    bus.mdin   = '0;
    for (int i = 0; i < 2**MEM_AW; i++) model_mem[i] = '0;
    repeat (3) step();
    test_reset();
    reset = 1'b0;
    step();
    test_reset();
    // The array is not reset, so give the whole block a known value through the backdoor.
    for (int k = 0; k < 4; k++) preload(MEM_AW'(12'h104 + k), '0);
    test_read();
    test_stall();
    test_write_readback();
    test_simultaneous();
    test_reset_wrap();
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
